// File: rtl/gbe_rx_port_demux_if.sv
// MAC receive byte stream into the port demux: data, valid and end-of-frame status strobes.
interface gbe_rx_port_demux_if;
  logic [7:0] mac_rx_data;
  logic       mac_rx_dvld;
  logic       mac_rx_goodframe;
  logic       mac_rx_badframe;

  modport master (output mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe);
  modport slave  (input  mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe);
endinterface

// File: rtl/gbe_rx_port_demux.sv
// Receive-side Ethernet/IPv4/UDP parser that steers matching UDP payloads to one of N local ports,
// trims Ethernet padding via the UDP length and keeps saturating miss/error counters.
module gbe_rx_port_demux #(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned CH_W         = 2,
  parameter bit          ACCEPT_BCAST = 1'b0
) (
  input  logic                   mac_clk,
  input  logic                   mac_rst,
  gbe_rx_port_demux_if.slave     rx,
  input  logic                   local_enable,
  input  logic [47:0]            local_mac,
  input  logic [31:0]            local_ip,
  input  logic [16*N_PORTS-1:0]  local_ports,
  input  logic [N_PORTS-1:0]     port_en,
  output logic [7:0]             out_data,
  output logic                   out_dvld,
  output logic [CH_W-1:0]        out_chan,
  output logic [31:0]            out_srcip,
  output logic [15:0]            out_srcport,
  output logic                   out_eof,
  output logic                   out_badframe,
  output logic [15:0]            miss_cnt,
  output logic [15:0]            err_cnt
);

  localparam int unsigned OFF_W = 11;
  localparam logic [OFF_W-1:0] OFF_MAX = '1;

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HDR, S_PAYLOAD, S_PAD, S_DROP} state_t;

  state_t           state, st_b;
  logic [OFF_W-1:0] off;
  logic [7:0]       d;
  logic             dv, end_c, bad_c;
  logic             mac_run, bc_run, mac_now, bc_now;
  logic [7:0]       mac_byte, ip_byte, dport_hi, len_hi;
  logic [1:0]       ip_idx;
  logic [15:0]      udp_len, remaining, rem_b;
  logic [31:0]      srcip_sh;
  logic [15:0]      srcport_sh;
  logic [CH_W-1:0]  chan_q, port_idx;
  logic             port_hit, hdr_ok, fwd, accept;

  assign d     = rx.mac_rx_data;
  assign dv    = rx.mac_rx_dvld;
  assign end_c = rx.mac_rx_goodframe | rx.mac_rx_badframe;

  // Per-byte header field check for the byte at the current offset
  always_comb begin
    mac_byte = 8'(local_mac >> (6'd40 - {off[2:0], 3'b000}));
    ip_idx   = 2'(off - 11'd30);
    ip_byte  = 8'(local_ip >> (5'd24 - {ip_idx, 3'b000}));
    mac_now  = ((off == '0) || mac_run) && (d == mac_byte);
    bc_now   = ((off == '0) || bc_run) && (d == 8'hFF);
    port_hit = 1'b0;
    port_idx = '0;
    // Descending scan so the lowest matching index is the one left standing
    for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
      if (port_en[i] && (local_ports[16*i +: 16] == {dport_hi, d})) begin
        port_hit = 1'b1;
        port_idx = CH_W'(i);
      end
    end
    hdr_ok = 1'b1;
    if (off < 11'd6)                         hdr_ok = mac_now || (ACCEPT_BCAST && bc_now);
    else if (off == 11'd12)                  hdr_ok = (d == 8'h08);
    else if (off == 11'd13)                  hdr_ok = (d == 8'h00);
    else if (off == 11'd14)                  hdr_ok = (d == 8'h45);
    else if (off == 11'd23)                  hdr_ok = (d == 8'h11);
    else if (off >= 11'd30 && off <= 11'd33) hdr_ok = (d == ip_byte);
    else if (off == 11'd37)                  hdr_ok = port_hit;
    else if (off == 11'd39)                  hdr_ok = ({len_hi, d} >= 16'd8);
  end

  // State after consuming this cycle's byte; the end strobe is applied on top of it
  always_comb begin
    st_b   = state;
    rem_b  = remaining;
    fwd    = 1'b0;
    accept = 1'b0;
    if (dv) begin
      unique case (state)
        S_IDLE: st_b = (local_enable && hdr_ok) ? S_HDR : S_DROP;
        S_HDR: begin
          if (!hdr_ok) begin
            st_b = S_DROP;
          end else if (off == 11'd41) begin
            accept = 1'b1;
            rem_b  = udp_len - 16'd8;
            st_b   = (rem_b == 16'd0) ? S_PAD : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          fwd   = 1'b1;
          rem_b = remaining - 16'd1;
          if (rem_b == 16'd0) st_b = S_PAD;
        end
        default: ;
      endcase
    end
    bad_c = rx.mac_rx_badframe || (rem_b != 16'd0);
  end

  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      state        <= S_SYNC;
      off          <= '0;
      mac_run      <= 1'b0;
      bc_run       <= 1'b0;
      dport_hi     <= '0;
      len_hi       <= '0;
      udp_len      <= '0;
      remaining    <= '0;
      srcip_sh     <= '0;
      srcport_sh   <= '0;
      chan_q       <= '0;
      out_data     <= '0;
      out_dvld     <= 1'b0;
      out_chan     <= '0;
      out_srcip    <= '0;
      out_srcport  <= '0;
      out_eof      <= 1'b0;
      out_badframe <= 1'b0;
      miss_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      out_dvld     <= fwd;
      out_data     <= fwd ? d : 8'h00;
      out_eof      <= 1'b0;
      out_badframe <= 1'b0;
      if (state == S_SYNC) begin
        // Leave only on an idle cycle so a frame already in flight is never parsed
        if (!dv) begin
          state <= S_IDLE;
          off   <= '0;
        end
      end else begin
        state     <= st_b;
        remaining <= rem_b;
        if (dv) begin
          if (off != OFF_MAX) off <= off + 11'd1;
          if (off < 11'd6) begin
            mac_run <= mac_now;
            bc_run  <= bc_now;
          end
          if (state == S_HDR) begin
            if (off >= 11'd26 && off <= 11'd29) srcip_sh <= {srcip_sh[23:0], d};
            if (off == 11'd34 || off == 11'd35) srcport_sh <= {srcport_sh[7:0], d};
            if (off == 11'd36) dport_hi <= d;
            if (off == 11'd37) chan_q <= port_idx;
            if (off == 11'd38) len_hi <= d;
            if (off == 11'd39) udp_len <= {len_hi, d};
          end
        end
        if (accept) begin
          out_chan    <= chan_q;
          out_srcip   <= srcip_sh;
          out_srcport <= srcport_sh;
        end
        if (end_c) begin
          state <= S_IDLE;
          off   <= '0;
          if (st_b == S_PAYLOAD || st_b == S_PAD) begin
            out_eof      <= 1'b1;
            out_badframe <= bad_c;
            if (bad_c && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
          end else if ((st_b == S_HDR || st_b == S_DROP) && !rx.mac_rx_badframe &&
                       local_enable && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gbe_rx_port_demux.sv
// Self-checking bench for gbe_rx_port_demux: directed vector table, reset/saturation sequences
// and randomized frames scored against a frame-level reference model.
module tb_gbe_rx_port_demux;
  localparam int unsigned N_PORTS = 4;
  localparam int unsigned CH_W    = 2;
  localparam logic [31:0] SRC_IP  = 32'h0A000009;

  logic mac_clk = 1'b0;
  logic mac_rst;
  always #5 mac_clk = ~mac_clk;

  gbe_rx_port_demux_if rx_if();

  logic                  local_enable;
  logic [47:0]           local_mac;
  logic [31:0]           local_ip;
  logic [16*N_PORTS-1:0] local_ports;
  logic [N_PORTS-1:0]    port_en;
  logic [7:0]            out_data;
  logic                  out_dvld;
  logic [CH_W-1:0]       out_chan;
  logic [31:0]           out_srcip;
  logic [15:0]           out_srcport;
  logic                  out_eof;
  logic                  out_badframe;
  logic [15:0]           miss_cnt;
  logic [15:0]           err_cnt;

  gbe_rx_port_demux #(.N_PORTS(N_PORTS), .CH_W(CH_W), .ACCEPT_BCAST(1'b0)) dut (
    .mac_clk(mac_clk), .mac_rst(mac_rst), .rx(rx_if),
    .local_enable(local_enable), .local_mac(local_mac), .local_ip(local_ip),
    .local_ports(local_ports), .port_en(port_en),
    .out_data(out_data), .out_dvld(out_dvld), .out_chan(out_chan),
    .out_srcip(out_srcip), .out_srcport(out_srcport), .out_eof(out_eof),
    .out_badframe(out_badframe), .miss_cnt(miss_cnt), .err_cnt(err_cnt)
  );

  int n_pass = 0, n_total = 0;
  logic [7:0] frm[$], pay[$], got[$], exp_pay[$];
  int   eof_total = 0, eof_with_dvld = 0;
  logic last_bad = 1'b0;

  logic        exp_eof, exp_bad;
  logic [1:0]  exp_chan;
  logic [31:0] exp_ip;
  logic [15:0] exp_port;
  int          exp_miss, exp_err;

  // Output collector
  always @(negedge mac_clk) begin
    if (out_dvld) got.push_back(out_data);
    if (out_eof) begin
      eof_total++;
      last_bad = out_badframe;
      if (out_dvld) eof_with_dvld++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fill_pay(input logic [31:0] first4, input int n);
    pay.delete();
    for (int k = 0; k < n; k++) begin
      if (k < 4) pay.push_back(first4[8*(3-k) +: 8]);
      else       pay.push_back(8'(k*7 + 3));
    end
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] vihl,
                       input logic [7:0] proto, input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen,
                       input int npay, input int pad_to);
    logic [47:0] smac;
    logic [15:0] tl;
    smac = 48'h020000000001;
    tl   = ulen + 16'd20;
    frm.delete();
    for (int j = 0; j < 6; j++) frm.push_back(dmac[8*(5-j) +: 8]);
    for (int j = 0; j < 6; j++) frm.push_back(smac[8*(5-j) +: 8]);
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(vihl); frm.push_back(8'h00);
    frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
    for (int j = 0; j < 4; j++) frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(proto);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int j = 0; j < 4; j++) frm.push_back(sip[8*(3-j) +: 8]);
    for (int j = 0; j < 4; j++) frm.push_back(dip[8*(3-j) +: 8]);
    frm.push_back(sp[15:8]);   frm.push_back(sp[7:0]);
    frm.push_back(dp[15:8]);   frm.push_back(dp[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int k = 0; k < npay; k++) frm.push_back(pay[k]);
    while (frm.size() < pad_to) frm.push_back(8'h00);
  endtask

  task automatic send(input bit bad, input bit gaps);
    for (int k = 0; k < frm.size(); k++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge mac_clk);
        rx_if.mac_rx_dvld = 1'b0;
      end
      @(negedge mac_clk);
      rx_if.mac_rx_data = frm[k];
      rx_if.mac_rx_dvld = 1'b1;
    end
    @(negedge mac_clk);
    rx_if.mac_rx_dvld      = 1'b0;
    rx_if.mac_rx_goodframe = !bad;
    rx_if.mac_rx_badframe  = bad;
    @(negedge mac_clk);
    rx_if.mac_rx_goodframe = 1'b0;
    rx_if.mac_rx_badframe  = 1'b0;
    repeat (3) @(negedge mac_clk);
  endtask

  // Frame-level reference: decide match from the whole byte array, then derive outputs
  task automatic model(input bit bad);
    int L, ch, r, fw;
    bit m;
    logic [15:0] dp, ul;
    L = frm.size();
    exp_pay.delete();
    exp_eof = 1'b0;
    exp_bad = 1'b0;
    m = local_enable && (L >= 42);
    if (m) begin
      for (int j = 0; j < 6; j++) if (frm[j] != local_mac[8*(5-j) +: 8]) m = 0;
      if ({frm[12], frm[13]} != 16'h0800 || frm[14] != 8'h45 || frm[23] != 8'h11) m = 0;
      for (int j = 0; j < 4; j++) if (frm[30+j] != local_ip[8*(3-j) +: 8]) m = 0;
      dp = {frm[36], frm[37]};
      ul = {frm[38], frm[39]};
      ch = -1;
      for (int i = 0; i < int'(N_PORTS); i++)
        if (ch < 0 && port_en[i] && local_ports[16*i +: 16] == dp) ch = i;
      if (ch < 0 || ul < 16'd8) m = 0;
    end
    if (m) begin
      r  = int'(ul) - 8;
      fw = (L - 42 < r) ? L - 42 : r;
      for (int k = 0; k < fw; k++) exp_pay.push_back(frm[42+k]);
      exp_eof  = 1'b1;
      exp_bad  = bad || (fw < r);
      if (exp_bad && exp_err < 65535) exp_err++;
      exp_chan = 2'(ch);
      exp_ip   = {frm[26], frm[27], frm[28], frm[29]};
      exp_port = {frm[34], frm[35]};
    end else if (!bad && local_enable && exp_miss < 65535) begin
      exp_miss++;
    end
  endtask

  task automatic cmp(input string tag, input int b0, input int e0);
    int nb, mis;
    nb  = got.size() - b0;
    mis = 0;
    chk({tag, " nbytes"}, 64'(nb), 64'(exp_pay.size()));
    for (int k = 0; k < nb && k < exp_pay.size(); k++) if (got[b0+k] !== exp_pay[k]) mis++;
    chk({tag, " data_mismatches"}, 64'(mis), 64'd0);
    chk({tag, " eof_count"}, 64'(eof_total - e0), 64'(exp_eof));
    if (exp_eof) chk({tag, " badframe"}, 64'(last_bad), 64'(exp_bad));
    chk({tag, " chan"}, 64'(out_chan), 64'(exp_chan));
    chk({tag, " srcip"}, 64'(out_srcip), 64'(exp_ip));
    chk({tag, " srcport"}, 64'(out_srcport), 64'(exp_port));
    chk({tag, " miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  typedef struct {
    bit          en;
    logic [3:0]  pen;
    logic [31:0] dip;
    logic [15:0] dp;
    logic [15:0] ulen;
    int          npay;
    int          pad_to;
    bit          endbad;
    logic [31:0] first4;
    int          exp_n;
    bit          x_eof;
    bit          x_bad;
    logic [1:0]  x_chan;
    int          x_miss;
    int          x_err;
  } vec_t;

  localparam int NV = 12;
  vec_t tv[NV];

  initial begin
    int b0, e0, sel, nrm, npay, cut;
    bit bad;
    logic [47:0] dm;
    logic [15:0] et, dp, ul;
    logic [7:0]  vi, pr;
    logic [31:0] dip;

    //          en pen    dip           dp        ulen   npay pad endbad first4        n  eof bad ch miss err
    tv[0]  = '{1, 4'hF, 32'h0A000005, 16'd7149, 16'd12,  4,   0, 0, 32'hDEADBEEF,  4, 1, 0, 1, 0, 0};
    tv[1]  = '{1, 4'hF, 32'h0A000005, 16'h1234, 16'd9,   1,  60, 0, 32'h5A000000,  1, 1, 0, 2, 0, 0};
    tv[2]  = '{1, 4'hF, 32'h0A000006, 16'd7148, 16'd12,  4,  60, 0, 32'h01020304,  0, 0, 0, 0, 1, 0};
    tv[3]  = '{1, 4'hE, 32'h0A000005, 16'd7148, 16'd12,  4,  60, 0, 32'h01020304,  0, 0, 0, 0, 2, 0};
    tv[4]  = '{1, 4'hF, 32'h0A000005, 16'd7148, 16'd12,  4,  60, 1, 32'hCAFEF00D,  4, 1, 1, 0, 2, 1};
    tv[5]  = '{1, 4'hF, 32'h0A000005, 16'd7149, 16'd100, 20,  0, 0, 32'h10203040, 20, 1, 1, 1, 2, 2};
    tv[6]  = '{1, 4'hF, 32'h0A000005, 16'd7148, 16'd8,   0,  60, 0, 32'h0,         0, 1, 0, 0, 2, 2};
    tv[7]  = '{1, 4'hF, 32'h0A000005, 16'd7148, 16'd7,   0,  60, 0, 32'h0,         0, 0, 0, 0, 3, 2};
    tv[8]  = '{1, 4'hF, 32'h0A000006, 16'd7148, 16'd12,  4,  60, 1, 32'h0,         0, 0, 0, 0, 3, 2};
    tv[9]  = '{0, 4'hF, 32'h0A000005, 16'd7148, 16'd12,  4,  60, 0, 32'h0,         0, 0, 0, 0, 3, 2};
    tv[10] = '{1, 4'hF, 32'h0A000005, 16'd9999, 16'd12,  4,  60, 0, 32'h0,         0, 0, 0, 0, 4, 2};
    tv[11] = '{1, 4'hF, 32'h0A000005, 16'h1234, 16'd20, 12,   0, 0, 32'h99887766, 12, 1, 0, 2, 4, 2};

    local_mac              = 48'h02020A000005;
    local_ip               = 32'h0A000005;
    local_ports            = {16'h1234, 16'h1234, 16'd7149, 16'd7148};
    port_en                = 4'hF;
    local_enable           = 1'b1;
    rx_if.mac_rx_data      = 8'h00;
    rx_if.mac_rx_dvld      = 1'b0;
    rx_if.mac_rx_goodframe = 1'b0;
    rx_if.mac_rx_badframe  = 1'b0;
    mac_rst                = 1'b1;
    repeat (3) @(negedge mac_clk);
    mac_rst = 1'b0;

    chk("reset out_dvld", 64'(out_dvld), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_eof", 64'(out_eof), 64'd0);
    chk("reset out_badframe", 64'(out_badframe), 64'd0);
    chk("reset out_chan", 64'(out_chan), 64'd0);
    chk("reset out_srcip", 64'(out_srcip), 64'd0);
    chk("reset miss_cnt", 64'(miss_cnt), 64'd0);
    chk("reset err_cnt", 64'(err_cnt), 64'd0);
    @(negedge mac_clk);

    // Directed vector table
    exp_chan = 2'd0; exp_ip = 32'd0; exp_port = 16'd0;
    for (int i = 0; i < NV; i++) begin
      local_enable = tv[i].en;
      port_en      = tv[i].pen;
      fill_pay(tv[i].first4, tv[i].npay);
      build(local_mac, 16'h0800, 8'h45, 8'h11, SRC_IP, tv[i].dip, 16'(5000 + i),
            tv[i].dp, tv[i].ulen, tv[i].npay, tv[i].pad_to);
      b0 = got.size();
      e0 = eof_total;
      send(tv[i].endbad, bit'(i % 2));
      exp_pay.delete();
      for (int k = 0; k < tv[i].exp_n; k++) exp_pay.push_back(pay[k]);
      exp_eof  = tv[i].x_eof;
      exp_bad  = tv[i].x_bad;
      exp_miss = tv[i].x_miss;
      exp_err  = tv[i].x_err;
      if (tv[i].x_eof) begin
        exp_chan = tv[i].x_chan;
        exp_ip   = SRC_IP;
        exp_port = 16'(5000 + i);
      end
      cmp($sformatf("vec%0d", i), b0, e0);
    end

    // Reset in the middle of a frame while bytes keep arriving
    local_enable = 1'b1;
    port_en      = 4'hF;
    fill_pay(32'h11223344, 8);
    build(local_mac, 16'h0800, 8'h45, 8'h11, SRC_IP, 32'h0A000005, 16'd6000, 16'd7148,
          16'd16, 8, 0);
    for (int k = 0; k < 22; k++) begin
      @(negedge mac_clk);
      mac_rst           = (k >= 20);
      rx_if.mac_rx_data = frm[k];
      rx_if.mac_rx_dvld = 1'b1;
    end
    @(negedge mac_clk);
    mac_rst           = 1'b0;
    rx_if.mac_rx_data = frm[22];
    b0 = got.size();
    e0 = eof_total;
    chk("rst out_dvld", 64'(out_dvld), 64'd0);
    chk("rst out_chan", 64'(out_chan), 64'd0);
    chk("rst out_srcip", 64'(out_srcip), 64'd0);
    chk("rst out_srcport", 64'(out_srcport), 64'd0);
    chk("rst miss_cnt", 64'(miss_cnt), 64'd0);
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
    for (int k = 23; k < frm.size(); k++) begin
      @(negedge mac_clk);
      rx_if.mac_rx_data = frm[k];
    end
    @(negedge mac_clk);
    rx_if.mac_rx_dvld      = 1'b0;
    rx_if.mac_rx_goodframe = 1'b1;
    @(negedge mac_clk);
    rx_if.mac_rx_goodframe = 1'b0;
    repeat (3) @(negedge mac_clk);
    exp_pay.delete();
    exp_eof = 1'b0; exp_bad = 1'b0;
    exp_chan = 2'd0; exp_ip = 32'd0; exp_port = 16'd0;
    exp_miss = 0; exp_err = 0;
    cmp("rst_tail", b0, e0);
    b0 = got.size();
    e0 = eof_total;
    model(1'b0);
    send(1'b0, 1'b0);
    cmp("rst_next", b0, e0);

    // Randomized frames against the reference model
    for (int r = 0; r < 60; r++) begin
      sel = int'($urandom_range(0, 9));
      dm  = (sel == 0) ? 48'hFFFFFFFFFFFF :
            (sel == 1) ? {$urandom(), 16'h0A0B} : local_mac;
      et  = ($urandom_range(0, 15) == 0) ? 16'h86DD : 16'h0800;
      vi  = ($urandom_range(0, 15) == 0) ? 8'h46 : 8'h45;
      pr  = ($urandom_range(0, 15) == 0) ? 8'h06 : 8'h11;
      dip = ($urandom_range(0, 7) == 0) ? 32'h0A000006 : local_ip;
      case ($urandom_range(0, 4))
        0:       dp = 16'd7148;
        1:       dp = 16'd7149;
        2:       dp = 16'h1234;
        3:       dp = 16'($urandom());
        default: dp = 16'd7149;
      endcase
      ul   = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(8, 40));
      nrm  = (ul >= 16'd8) ? int'(ul) - 8 : 0;
      npay = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nrm)) : nrm;
      port_en      = 4'($urandom());
      local_enable = ($urandom_range(0, 9) != 0);
      bad          = ($urandom_range(0, 5) == 0);
      fill_pay($urandom(), npay);
      build(dm, et, vi, pr, 32'($urandom()), dip, 16'($urandom()), dp, ul, npay,
            ($urandom_range(0, 1) == 0) ? 60 : 0);
      if ($urandom_range(0, 7) == 0) begin
        cut = int'($urandom_range(1, frm.size()));
        while (frm.size() > cut) void'(frm.pop_back());
      end
      b0 = got.size();
      e0 = eof_total;
      model(bad);
      send(bad, bit'(r % 2));
      cmp($sformatf("rand%0d", r), b0, e0);
    end

    // Back-to-back one-byte unmatched frames drive miss_cnt into saturation
    local_enable = 1'b1;
    port_en      = 4'hF;
    e0 = eof_total;
    for (int k = 0; k < 65540; k++) begin
      @(negedge mac_clk);
      rx_if.mac_rx_data      = 8'h00;
      rx_if.mac_rx_dvld      = 1'b1;
      rx_if.mac_rx_goodframe = 1'b1;
    end
    @(negedge mac_clk);
    rx_if.mac_rx_dvld      = 1'b0;
    rx_if.mac_rx_goodframe = 1'b0;
    repeat (3) @(negedge mac_clk);
    chk("sat miss_cnt", 64'(miss_cnt), 64'hFFFF);
    chk("sat eof_count", 64'(eof_total - e0), 64'd0);
    chk("eof_with_dvld", 64'(eof_with_dvld), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
